temporizador_nivel2: RTL and testbench
======================================

TEMPORIZADOR_NIVEL2 -- requirements
Module: temporizador_nivel2

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock, rising-edge active; the same clock drives the time-entry stage.
REQ-002 The block SHALL have port clearn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port D, input, 4 bits: BCD digit from the time-entry stage.
REQ-004 The block SHALL have port loadn, input, 1 bit: active-low digit-load strobe from the time-entry stage.
REQ-005 The block SHALL have port pgt_1Hz, input, 1 bit: 1 Hz tick; a low-to-high transition is one tick.
REQ-006 The block SHALL have port en, input, 1 bit: active-high count enable; low means entry mode.
REQ-007 The block SHALL have port sec_ones, output, 4 bits: BCD seconds units.
REQ-008 The block SHALL have port sec_tens, output, 4 bits: BCD seconds tens.
REQ-009 The block SHALL have port mins, output, 4 bits: BCD minutes.
REQ-010 The block SHALL have port zero, output, 1 bit: high while all three digits are 0.

Function
REQ-011 The block SHALL register loadn and pgt_1Hz once on clk, and SHALL detect edges by comparing each input with its registered copy.
REQ-012 The block SHALL treat a loadn high-to-low transition as a load event; a loadn held low for N cycles SHALL produce exactly one load event.
REQ-013 On a load event with en=0 and D<=9, the digits SHALL shift left one position on the next clk edge: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=D; the old mins value is discarded.
REQ-014 A load event with en=1 or with D>9 SHALL be ignored and SHALL change no state.
REQ-015 The block SHALL treat a pgt_1Hz low-to-high transition as a tick event; a tick SHALL take effect only when en=1 and zero=0.
REQ-016 Each accepted tick SHALL decrement the count by one second in BCD.
- sec_ones 1..9: decrement sec_ones.
- sec_ones=0: sec_ones<=9 and borrow from tens.
- Borrow with sec_tens>0: decrement sec_tens.
- Borrow with sec_tens=0: sec_tens<=5 and decrement mins.
REQ-017 A digit pattern loaded with sec_tens>5 (for example 0:75) SHALL count down arithmetically (75,74,...,70,69,...) with no clamping.
REQ-018 At 0:00 the count SHALL hold; further ticks SHALL be ignored; there SHALL be no wrap to 9:59.
REQ-019 zero SHALL be combinationally derived from the digit registers; it SHALL update in the same cycle as the digits.
REQ-020 Digit outputs SHALL update exactly one clk edge after the cycle in which the registered edge is detected (two clk edges after the input transition).
REQ-021 Dropping en to 0 mid-count SHALL freeze the digits; raising it again SHALL resume the countdown from the frozen value.

Reset
REQ-022 While clearn=0 the block SHALL asynchronously set sec_ones=0, sec_tens=0, mins=0, zero=1, and both edge registers to 1 (loadn) and 0 (pgt_1Hz).
REQ-023 Releasing clearn while loadn=0 SHALL NOT produce a load event; releasing it while pgt_1Hz=1 SHALL produce no tick until the next low-to-high transition.
REQ-024 Reset asserted mid-countdown SHALL abort the countdown immediately, with no pending event surviving.

Configuration
REQ-025 With macro TEMPORIZADOR_DONE_PULSE_EN defined, the block SHALL add output port done (1 bit); done SHALL pulse high for exactly one clk cycle when an accepted tick brings the count to 0:00.
REQ-026 With the macro defined, done SHALL be 0 at reset and SHALL NOT pulse on reset or on a load that leaves the count at 0:00.
REQ-027 Without the macro, the done port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Scenario: en=0, three load events with D=1, 3, 0 -> mins=1, sec_tens=3, sec_ones=0, zero=0.
REQ-029 Scenario: load 1:00, en=1, one tick -> 0:59; 59 further ticks -> 0:00 with zero=1; done pulses once if configured; an extra tick leaves 0:00.
REQ-030 Scenario: loadn held low 10 cycles with D=7 -> exactly one shift, sec_ones=7; D=12 load -> no change.
REQ-031 Scenario: counting from 0:05 with en=1, load event with D=9 -> ignored; en=0 after two ticks -> holds 0:03 across further ticks.
REQ-032 Scenario: clearn pulsed low during countdown at 0:42 -> all digits 0 and zero=1 immediately, without waiting for clk; release with pgt_1Hz=1 -> no tick.
REQ-033 Scenario: load 0:75, en=1, six ticks -> 0:69.

Source files
------------

// File: rtl/temporizador_nivel2.sv
// temporizador_nivel2 -- three-digit BCD countdown timer (M:ST) with serial
// digit entry. Digits are shifted in from the right while en=0 and count down
// once per 1 Hz tick while en=1, holding at 0:00.
// Optional feature: define TEMPORIZADOR_DONE_PULSE_EN to add a one-cycle
// 'done' output that fires when a tick brings the count to 0:00.
module temporizador_nivel2 (
   input  logic       clk,
   input  logic       clearn,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       en,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] mins,
`ifdef TEMPORIZADOR_DONE_PULSE_EN
   output logic       done,
`endif
   output logic       zero
);

   // Registered copies of the strobes used for edge detection.
   logic       loadn_q, loadn_d;
   logic       pgt_q, pgt_d;
   // Cleared by reset; the first clk edge after release only seeds the
   // registered copies, so a level already present at release never
   // looks like an edge.
   logic       armed_q, armed_d;
   // Detected edges are held one cycle before they touch the digits.
   logic       load_pend_q, load_pend_d;
   logic       tick_pend_q, tick_pend_d;
   logic [3:0] d_q, d_d;
   // Digit registers.
   logic [3:0] sec_ones_q, sec_ones_d;
   logic [3:0] sec_tens_q, sec_tens_d;
   logic [3:0] mins_q, mins_d;

   logic       load_evt, tick_evt;
   logic       load_ok, tick_ok;

   // Edge detection: input compared against its registered copy.
   always_comb begin
      load_evt = armed_q & loadn_q & ~loadn;
      tick_evt = armed_q & ~pgt_q & pgt_1Hz;
   end

   // Acceptance of pending events against the current mode and count.
   always_comb begin
      load_ok = load_pend_q & ~en & (d_q <= 4'd9);
      tick_ok = tick_pend_q & en & ~zero;
   end

   // Next-state for the edge-detection and pending-event registers.
   always_comb begin
      armed_d     = 1'b1;
      loadn_d     = loadn;
      pgt_d       = pgt_1Hz;
      load_pend_d = load_evt;
      tick_pend_d = tick_evt;
      d_d         = load_evt ? D : d_q;
   end

   // Next-state for the digits: left shift on load, BCD borrow chain on tick.
   always_comb begin
      sec_ones_d = sec_ones_q;
      sec_tens_d = sec_tens_q;
      mins_d     = mins_q;
      if (load_ok) begin
         mins_d     = sec_tens_q;
         sec_tens_d = sec_ones_q;
         sec_ones_d = d_q;
      end else if (tick_ok) begin
         if (sec_ones_q != 4'd0) begin
            sec_ones_d = sec_ones_q - 4'd1;
         end else begin
            sec_ones_d = 4'd9;
            if (sec_tens_q != 4'd0) begin
               sec_tens_d = sec_tens_q - 4'd1;
            end else begin
               // zero=0 guarantees mins is non-zero on this path.
               sec_tens_d = 4'd5;
               mins_d     = mins_q - 4'd1;
            end
         end
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         loadn_q     <= 1'b1;
         pgt_q       <= 1'b0;
         armed_q     <= 1'b0;
         load_pend_q <= 1'b0;
         tick_pend_q <= 1'b0;
         d_q         <= 4'd0;
         sec_ones_q  <= 4'd0;
         sec_tens_q  <= 4'd0;
         mins_q      <= 4'd0;
      end else begin
         loadn_q     <= loadn_d;
         pgt_q       <= pgt_d;
         armed_q     <= armed_d;
         load_pend_q <= load_pend_d;
         tick_pend_q <= tick_pend_d;
         d_q         <= d_d;
         sec_ones_q  <= sec_ones_d;
         sec_tens_q  <= sec_tens_d;
         mins_q      <= mins_d;
      end
   end

   // Outputs follow the digit registers directly.
   always_comb begin
      sec_ones = sec_ones_q;
      sec_tens = sec_tens_q;
      mins     = mins_q;
      zero     = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (mins_q == 4'd0);
   end

`ifdef TEMPORIZADOR_DONE_PULSE_EN
   logic done_q, done_d;

   // done is set only by a tick that lands on 0:00, so loads and reset never fire it.
   always_comb begin
      done_d = tick_ok && (sec_ones_d == 4'd0) && (sec_tens_d == 4'd0) && (mins_d == 4'd0);
   end

   // done register, cleared asynchronously with the rest of the state.
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign done = done_q;
`endif

endmodule

// File: tb/tb_temporizador_nivel2.sv
// Testbench for temporizador_nivel2: a digit-level model feeds a scoreboard
// queue with the expected {mins, sec_tens, sec_ones, zero} after every
// load/tick; entries are popped and compared once the DUT has settled.
module tb_temporizador_nivel2;

   logic       clk = 1'b0;
   logic       clearn = 1'b0;
   logic [3:0] D = 4'd0;
   logic       loadn = 1'b1;
   logic       pgt_1Hz = 1'b0;
   logic       en = 1'b0;
   logic [3:0] sec_ones, sec_tens, mins;
   logic       zero;
`ifdef TEMPORIZADOR_DONE_PULSE_EN
   logic       done;
   int         done_cnt = 0;
`endif

   temporizador_nivel2 dut (
      .clk      (clk),
      .clearn   (clearn),
      .D        (D),
      .loadn    (loadn),
      .pgt_1Hz  (pgt_1Hz),
      .en       (en),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .mins     (mins),
`ifdef TEMPORIZADOR_DONE_PULSE_EN
      .done     (done),
`endif
      .zero     (zero)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   int m_mins = 0, m_tens = 0, m_ones = 0;
   logic [15:0] exp_q[$];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

`ifdef TEMPORIZADOR_DONE_PULSE_EN
   always @(negedge clk) if (done === 1'b1) done_cnt++;
`endif

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [15:0] model_pack();
      logic z;
      z = (m_mins == 0) && (m_tens == 0) && (m_ones == 0);
      return {m_mins[3:0], m_tens[3:0], m_ones[3:0], 3'b000, z};
   endfunction

   function automatic logic [15:0] dut_pack();
      return {mins, sec_tens, sec_ones, 3'b000, zero};
   endfunction

   function automatic void model_load(input int d, input logic e);
      if (!e && d <= 9) begin
         m_mins = m_tens;
         m_tens = m_ones;
         m_ones = d;
      end
   endfunction

   function automatic void model_tick(input logic e);
      int n;
      if (e && !(m_mins == 0 && m_tens == 0 && m_ones == 0)) begin
         n = m_tens * 10 + m_ones;
         if (n > 0) n = n - 1;
         else begin
            n = 59;
            m_mins = m_mins - 1;
         end
         m_tens = n / 10;
         m_ones = n % 10;
      end
   endfunction

   // One load strobe; loadn stays low for roughly hold+3 cycles.
   task automatic do_load(input logic [3:0] d, input int hold, input bit chk_lat, input string tag);
      logic [15:0] old_exp, new_exp, got;
      old_exp = model_pack();
      model_load(int'(d), en);
      new_exp = model_pack();
      exp_q.push_back(new_exp);
      @(posedge clk); #1;
      D = d;
      loadn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (chk_lat) check("lat_edge1", dut_pack(), old_exp);
      @(negedge clk);
      if (chk_lat) check("lat_edge2", dut_pack(), new_exp);
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      loadn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      got = dut_pack();
      check(tag, got, exp_q.pop_front());
   endtask

   task automatic do_tick(input string tag);
      logic [15:0] got;
      model_tick(en);
      exp_q.push_back(model_pack());
      @(posedge clk); #1;
      pgt_1Hz = 1'b1;
      repeat (3) @(posedge clk); #1;
      pgt_1Hz = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      got = dut_pack();
      check(tag, got, exp_q.pop_front());
   endtask

   task automatic set_en(input logic v);
      @(posedge clk); #1;
      en = v;
   endtask

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #2 clearn = 1'b1;
      @(negedge clk);
      check("reset_state", dut_pack(), model_pack());
`ifdef TEMPORIZADOR_DONE_PULSE_EN
      check("done_reset", {15'd0, done}, 16'd0);
`endif

      // Entry 1,3,0 -> 1:30, with a latency check on the first load.
      do_load(4'd1, 0, 1'b1, "load_1");
      do_load(4'd3, 0, 1'b0, "load_3");
      do_load(4'd0, 0, 1'b0, "load_0");

      // Re-enter 1:00 (shifting 1,0,0 over 1:30).
      do_load(4'd1, 0, 1'b0, "load_100a");
      do_load(4'd0, 0, 1'b0, "load_100b");
      do_load(4'd0, 0, 1'b0, "load_100c");
`ifdef TEMPORIZADOR_DONE_PULSE_EN
      check("done_after_load", 16'(done_cnt), 16'd0);
`endif
      set_en(1'b1);
      do_tick("tick_059");
      for (int i = 0; i < 59; i++) do_tick($sformatf("tick_%0d", i));
      do_tick("tick_hold_000");
`ifdef TEMPORIZADOR_DONE_PULSE_EN
      check("done_pulses", 16'(done_cnt), 16'd1);
`endif

      // Long loadn low gives one shift; out-of-range digit is ignored.
      set_en(1'b0);
      do_load(4'd7, 7, 1'b0, "long_low_7");
      do_load(4'd12, 0, 1'b0, "bad_digit_12");

      // Count from 0:05; load while counting is ignored; freeze with en=0.
      do_load(4'd0, 0, 1'b0, "load_005a");
      do_load(4'd0, 0, 1'b0, "load_005b");
      do_load(4'd5, 0, 1'b0, "load_005c");
      set_en(1'b1);
      do_load(4'd9, 0, 1'b0, "load_en1_ignored");
      do_tick("tick_004");
      do_tick("tick_003");
      set_en(1'b0);
      do_tick("frozen_a");
      do_tick("frozen_b");
      set_en(1'b1);
      do_tick("resume_002");
      set_en(1'b0);

      // 0:75 counts down arithmetically.
      do_load(4'd0, 0, 1'b0, "load_075a");
      do_load(4'd7, 0, 1'b0, "load_075b");
      do_load(4'd5, 0, 1'b0, "load_075c");
      set_en(1'b1);
      for (int i = 0; i < 6; i++) do_tick($sformatf("tick75_%0d", i));
      set_en(1'b0);

      // Asynchronous clear at 0:42 with a tick pending.
      do_load(4'd0, 0, 1'b0, "load_042a");
      do_load(4'd4, 0, 1'b0, "load_042b");
      do_load(4'd2, 0, 1'b0, "load_042c");
      set_en(1'b1);
      @(posedge clk); #1;
      pgt_1Hz = 1'b1;
      @(posedge clk); #2;
      clearn = 1'b0;
      m_mins = 0; m_tens = 0; m_ones = 0;
      #1;
      check("async_clear", dut_pack(), model_pack());
      en = 1'b0;
      D = 4'd5;
      loadn = 1'b0;
      repeat (2) @(posedge clk);
      #2 clearn = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("release_no_event", dut_pack(), model_pack());
      @(posedge clk); #1;
      loadn = 1'b1;
      pgt_1Hz = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("after_release", dut_pack(), model_pack());
      // Entry still works after the clear.
      do_load(4'd8, 0, 1'b0, "load_after_clear");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
